// File: rtl/reg_slice.sv
// reg_slice
//
// Registered valid/ready pipeline slice with a one-entry skid buffer. The
// data/valid pair toward the register-primitive stages comes straight from
// flops, and the backward ready is also a flop, so no combinational path
// crosses the slice in either direction. Sustains one transfer per cycle
// and never drops or duplicates data under backpressure.
//
// Parameters:
//   WIDTH        data width in bits (>= 1)
//   RESET_VALUE  value loaded into out_data and the skid register on reset
//
// Ports:
//   clk        in   clock, all state updates on posedge
//   reset_n    in   synchronous active-low reset, highest priority
//   in_valid   in   upstream data valid
//   in_ready   out  slice can accept (registered)
//   in_data    in   upstream data [WIDTH-1:0]
//   out_valid  out  out_data valid (registered)
//   out_ready  in   downstream accepts
//   out_data   out  registered data [WIDTH-1:0]
//   clear      in   synchronous flush (only when REG_SLICE_CLEAR_EN is defined)
//
// Build option:
//   REG_SLICE_CLEAR_EN  adds the clear port and its flush logic.

module reg_slice #(
    parameter int               WIDTH       = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset_n,
`ifdef REG_SLICE_CLEAR_EN
    input  logic             clear,
`endif
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] main_data;
    logic [WIDTH-1:0] skid_data;

    logic             in_xfer;
    logic             out_xfer;
    logic             load_main_in;
    logic             load_main_skid;
    logic             load_skid;

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;
    assign out_data = main_data;

    // Next-state and register-load decode
    always_comb begin
        next_state     = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;

        case (state)
            EMPTY: begin
                if (in_xfer) begin
                    load_main_in = 1'b1;
                    next_state   = HALF;
                end
            end
            HALF: begin
                if (in_xfer && out_xfer) begin
                    load_main_in = 1'b1;
                end else if (in_xfer) begin
                    // Downstream stalled: park the new word in the skid.
                    load_skid  = 1'b1;
                    next_state = FULL;
                end else if (out_xfer) begin
                    next_state = EMPTY;
                end
            end
            FULL: begin
                // in_ready is low here, so only the drain side can move.
                if (out_xfer) begin
                    load_main_skid = 1'b1;
                    next_state     = HALF;
                end
            end
            default: begin
                next_state = EMPTY;
            end
        endcase

`ifdef REG_SLICE_CLEAR_EN
        // Flush drops both entries and any handshake on this edge; the data
        // registers keep their contents since they are never observed again.
        if (clear) begin
            next_state     = EMPTY;
            load_main_in   = 1'b0;
            load_main_skid = 1'b0;
            load_skid      = 1'b0;
        end
`endif
    end

    // Registered state, handshake outputs and data storage
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b0;
            main_data <= RESET_VALUE;
            skid_data <= RESET_VALUE;
        end else begin
            state     <= next_state;
            // Both handshake outputs are decoded from next_state so they are
            // true flops, aligned with the state they describe.
            out_valid <= (next_state != EMPTY);
            in_ready  <= (next_state != FULL);
            if (load_main_in) begin
                main_data <= in_data;
            end else if (load_main_skid) begin
                main_data <= skid_data;
            end
            if (load_skid) begin
                skid_data <= in_data;
            end
        end
    end

endmodule

// File: tb/tb_reg_slice.sv
// tb_reg_slice
//
// Directed bench for reg_slice (WIDTH=4, RESET_VALUE=4'h5). Inputs change
// 1 time unit after each rising edge; outputs are inspected at the same point.
// A monitor records every output transfer so ordering and loss can be checked,
// and protocol stability on both sides is checked each cycle.

module tb_reg_slice;

    localparam int WIDTH = 4;

    logic             clk;
    logic             reset_n;
    logic             clear;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] got_q[$];

    reg_slice #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (4'h5)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
`ifdef REG_SLICE_CLEAR_EN
        .clear     (clear),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Output-transfer monitor and protocol stability checks
    logic             out_stall_prev = 1'b0;
    logic [WIDTH-1:0] out_data_prev  = '0;
    logic             in_stall_prev  = 1'b0;
    logic [WIDTH-1:0] in_data_prev   = '0;

    always @(posedge clk) begin
        if (reset_n && !clear && out_valid && out_ready)
            got_q.push_back(out_data);
        if (reset_n && !clear && out_stall_prev)
            check("out_stable", {27'd0, out_valid, out_data}, {27'd0, 1'b1, out_data_prev});
        if (reset_n && !clear && in_stall_prev)
            check("in_stable", {27'd0, in_valid, in_data}, {27'd0, 1'b1, in_data_prev});
        out_stall_prev = reset_n && !clear && out_valid && !out_ready;
        out_data_prev  = out_data;
        in_stall_prev  = reset_n && !clear && in_valid && !in_ready;
        in_data_prev   = in_data;
    end

    task automatic check_queue(input string tag, input logic [WIDTH-1:0] exp[], input int n);
        check({tag, "_count"}, got_q.size(), n);
        for (int i = 0; i < n && i < got_q.size(); i++)
            check({tag, "_item"}, {28'd0, got_q[i]}, {28'd0, exp[i]});
    endtask

    initial begin
        logic [WIDTH-1:0] exp[];

        reset_n   = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        // Reset held for three cycles
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_out_valid", out_valid, 0);
            check("rst_in_ready", in_ready, 0);
            check("rst_out_data", out_data, 4'h5);
        end
        reset_n = 1'b1;
        step();
        check("rel_in_ready", in_ready, 1);
        check("rel_out_valid", out_valid, 0);

        // Streaming 1,2,3,4 with out_ready held high
        got_q.delete();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int v = 1; v <= 4; v++) begin
            in_data = 4'(v);
            step();
            check("stream_data", out_data, v);
            check("stream_valid", out_valid, 1);
            check("stream_ready", in_ready, 1);
        end
        in_valid = 1'b0;
        step();
        check("stream_drain_valid", out_valid, 0);
        exp = '{4'h1, 4'h2, 4'h3, 4'h4};
        check_queue("stream_q", exp, 4);

        // Backpressure: 7, 8 fill the slice, 9 is held off
        got_q.delete();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 4'h7;
        step();
        check("bp_half_ready", in_ready, 1);
        check("bp_half_data", out_data, 4'h7);
        in_data = 4'h8;
        step();
        check("bp_full_ready", in_ready, 0);
        check("bp_full_data", out_data, 4'h7);
        check("bp_full_valid", out_valid, 1);
        in_data = 4'h9;
        step();
        check("bp_hold_ready", in_ready, 0);
        check("bp_hold_data", out_data, 4'h7);
        out_ready = 1'b1;
        step();
        check("bp_drain1_data", out_data, 4'h8);
        check("bp_drain1_ready", in_ready, 1);
        step();
        check("bp_drain2_data", out_data, 4'h9);
        in_valid = 1'b0;
        step();
        check("bp_empty_valid", out_valid, 0);
        exp = '{4'h7, 4'h8, 4'h9};
        check_queue("bp_q", exp, 3);

        // Simultaneous transfer in HALF
        got_q.delete();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 4'h3;
        step();
        check("sim_half_data", out_data, 4'h3);
        out_ready = 1'b1;
        in_data   = 4'hA;
        step();
        check("sim_data", out_data, 4'hA);
        check("sim_valid", out_valid, 1);
        check("sim_ready", in_ready, 1);
        in_valid = 1'b0;
        step();
        check("sim_empty_valid", out_valid, 0);
        exp = '{4'h3, 4'hA};
        check_queue("sim_q", exp, 2);

        // Reset while FULL holding 1, 2
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 4'h1;
        step();
        in_data = 4'h2;
        step();
        check("mrst_full_ready", in_ready, 0);
        got_q.delete();
        in_valid = 1'b0;
        reset_n  = 1'b0;
        step();
        check("mrst_out_valid", out_valid, 0);
        check("mrst_out_data", out_data, 4'h5);
        check("mrst_in_ready", in_ready, 0);
        reset_n   = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        check("mrst_after_valid", out_valid, 0);
        check("mrst_after_ready", in_ready, 1);
        check("mrst_q_count", got_q.size(), 0);

`ifdef REG_SLICE_CLEAR_EN
        // Clear while FULL, with a pending input word C
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 4'hD;
        step();
        in_data = 4'hE;
        step();
        check("clr_full_ready", in_ready, 0);
        got_q.delete();
        clear   = 1'b1;
        in_data = 4'hC;
        step();
        clear    = 1'b0;
        in_valid = 1'b0;
        check("clr_out_valid", out_valid, 0);
        check("clr_in_ready", in_ready, 1);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) step();
        check("clr_after_valid", out_valid, 0);
        check("clr_q_count", got_q.size(), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
